// File: rtl/simple_logic_pipeline.sv
// Three-stage valid/ready pipeline computing (a+b)*(c+d) or |a-b|*|c-d|.
// Empty stages (bubbles) collapse so a stalled consumer lets upstream stages keep filling.
module simple_logic_pipeline #(
    parameter int unsigned W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W+1:0]   y
);

    localparam int unsigned OUT_W = 2*W + 2;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             v3_q, v3_d;
    logic [W:0]       s0_q, s0_d;
    logic [W:0]       s1_q, s1_d;
    logic [OUT_W-1:0] p_q,  p_d;
    logic [OUT_W-1:0] y_q,  y_d;

    logic             adv1, adv2, adv3;
    logic [W:0]       ab_sum, cd_sum, ab_dif, cd_dif;

    always_comb begin
        adv3 = !v3_q || out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
    end

    always_comb begin
        ab_sum = (W+1)'(a) + (W+1)'(b);
        cd_sum = (W+1)'(c) + (W+1)'(d);
        ab_dif = (a >= b) ? (W+1)'(a - b) : (W+1)'(b - a);
        cd_dif = (c >= d) ? (W+1)'(c - d) : (W+1)'(d - c);
    end

    // Each stage holds unless it advances; an advancing stage inherits its predecessor's valid.
    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        s0_d = s0_q;
        s1_d = s1_q;
        p_d  = p_q;
        y_d  = y_q;
        if (adv1) begin
            v1_d = in_valid;
            s0_d = mode ? ab_dif : ab_sum;
            s1_d = mode ? cd_dif : cd_sum;
        end
        if (adv2) begin
            v2_d = v1_q;
            p_d  = OUT_W'(s0_q) * OUT_W'(s1_q);
        end
        if (adv3) begin
            v3_d = v2_q;
            y_d  = p_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s0_q <= '0;
            s1_q <= '0;
            p_q  <= '0;
            y_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            s0_q <= s0_d;
            s1_q <= s1_d;
            p_q  <= p_d;
            y_q  <= y_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign y         = y_q;

endmodule
